// File: rtl/comparator_serial_responder.sv
// Digit-serial magnitude comparator with valid/ready on both sides.
// Scans operands MSB digit first and stops at the first differing digit.
module comparator_serial_responder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGIT  = 2,     // must divide WIDTH
    parameter bit          SIGNED = 1'b0   // 1: two's-complement compare
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             busy
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    CNT_TOP  = CW'(N - 1);
    localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sh_a, sh_a_d;
    logic [WIDTH-1:0] sh_b, sh_b_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             out_valid_d, gt_d, eq_d, lt_d;
    logic [DIGIT-1:0] dig_a, dig_b;
    logic             flip_msb;

    // Current digit pair; in signed mode the sign digit's MSB is inverted
    // in both operands so an unsigned compare orders them correctly.
    always_comb begin
        flip_msb = SIGNED && (cnt == CNT_TOP);
        dig_a    = sh_a[WIDTH-1 -: DIGIT] ^ (flip_msb ? MSB_MASK : '0);
        dig_b    = sh_b[WIDTH-1 -: DIGIT] ^ (flip_msb ? MSB_MASK : '0);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        sh_a_d      = sh_a;
        sh_b_d      = sh_b;
        cnt_d       = cnt;
        out_valid_d = out_valid;
        gt_d        = gt;
        eq_d        = eq;
        lt_d        = lt;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d = SCAN;
                    sh_a_d  = A;
                    sh_b_d  = B;
                    cnt_d   = CNT_TOP;
                end
            end
            SCAN: begin
                if (dig_a != dig_b) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    gt_d        = (dig_a > dig_b);
                    lt_d        = (dig_a < dig_b);
                end else if (cnt == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    eq_d        = 1'b1;
                end else begin
                    sh_a_d = sh_a << DIGIT;
                    sh_b_d = sh_b << DIGIT;
                    cnt_d  = cnt - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    gt_d        = 1'b0;
                    eq_d        = 1'b0;
                    lt_d        = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
        end else begin
            state     <= state_d;
            sh_a      <= sh_a_d;
            sh_b      <= sh_b_d;
            cnt       <= cnt_d;
            out_valid <= out_valid_d;
            gt        <= gt_d;
            eq        <= eq_d;
            lt        <= lt_d;
        end
    end

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_comparator_serial_responder.sv
// Directed bench: unsigned and signed instances share one stimulus stream.
module tb_comparator_serial_responder;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;
    localparam logic [2:0] R_NO = 3'b000;

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready;
    logic [7:0] a, b;
    logic       in_ready, out_valid, gt, eq, lt, busy;
    logic       in_ready_s, out_valid_s, gt_s, eq_s, lt_s, busy_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    comparator_serial_responder #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
        .gt(gt), .eq(eq), .lt(lt), .busy(busy)
    );

    comparator_serial_responder #(.WIDTH(8), .DIGIT(2), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .A(a), .B(b), .out_valid(out_valid_s), .out_ready(out_ready),
        .gt(gt_s), .eq(eq_s), .lt(lt_s), .busy(busy_s)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] exp_u;
        logic [2:0] exp_s;
        int         k;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One transaction from IDLE with out_ready high; checks latency and result.
    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        chk($sformatf("v%0d_in_ready_pre", idx), 32'(in_ready), 32'd1);
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = v.b;
        b = v.a;
        for (int c = 1; c <= v.k; c++) begin
            step();
            chk($sformatf("v%0d_in_ready_c%0d", idx, c), 32'(in_ready), 32'd0);
            chk($sformatf("v%0d_busy_c%0d", idx, c), 32'(busy), 32'd1);
            if (c < v.k) begin
                chk($sformatf("v%0d_early_valid_c%0d", idx, c), 32'(out_valid), 32'd0);
            end else begin
                chk($sformatf("v%0d_valid", idx), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d_res_u", idx), 32'({gt, eq, lt}), 32'(v.exp_u));
                chk($sformatf("v%0d_valid_s", idx), 32'(out_valid_s), 32'd1);
                chk($sformatf("v%0d_res_s", idx), 32'({gt_s, eq_s, lt_s}), 32'(v.exp_s));
            end
        end
        step();
        chk($sformatf("v%0d_post_valid", idx), 32'(out_valid), 32'd0);
        chk($sformatf("v%0d_post_res", idx), 32'({gt, eq, lt}), 32'(R_NO));
        chk($sformatf("v%0d_post_busy", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_post_in_ready", idx), 32'(in_ready), 32'd1);
    endtask

    initial begin
        int nres;

        vecs[0]  = '{8'h5A, 8'h5A, R_EQ, R_EQ, 4};
        vecs[1]  = '{8'h80, 8'h7F, R_GT, R_LT, 1};
        vecs[2]  = '{8'h12, 8'h13, R_LT, R_LT, 4};
        vecs[3]  = '{8'hC3, 8'hB3, R_GT, R_GT, 1};
        vecs[4]  = '{8'h63, 8'h53, R_GT, R_GT, 2};
        vecs[5]  = '{8'h34, 8'h38, R_LT, R_LT, 3};
        vecs[6]  = '{8'h01, 8'h00, R_GT, R_GT, 4};
        vecs[7]  = '{8'h00, 8'hFF, R_LT, R_GT, 1};
        vecs[8]  = '{8'h7F, 8'h80, R_LT, R_GT, 1};
        vecs[9]  = '{8'hFF, 8'hFE, R_GT, R_GT, 4};
        vecs[10] = '{8'hA7, 8'hA5, R_GT, R_GT, 4};
        vecs[11] = '{8'h80, 8'h80, R_EQ, R_EQ, 4};
        vecs[12] = '{8'h40, 8'hC0, R_LT, R_GT, 1};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 8'h00;
        b = 8'h00;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", 32'({gt, eq, lt}), 32'(R_NO));
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_vec(i);
        end

        // Backpressure: result held while out_ready low, new pair waits.
        out_ready = 1'b0;
        a = 8'h01;
        b = 8'h00;
        in_valid = 1'b1;
        step();
        a = 8'hFF;
        b = 8'hFF;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_res", 32'({gt, eq, lt}), 32'(R_GT));
        for (int j = 0; j < 5; j++) begin
            step();
            chk($sformatf("bp_hold_valid_%0d", j), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_res_%0d", j), 32'({gt, eq, lt}), 32'(R_GT));
            chk($sformatf("bp_hold_res_s_%0d", j), 32'({gt_s, eq_s, lt_s}), 32'(R_GT));
            chk($sformatf("bp_hold_in_ready_%0d", j), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c < 4) chk($sformatf("bp2_early_valid_c%0d", c), 32'(out_valid), 32'd0);
        end
        chk("bp2_valid", 32'(out_valid), 32'd1);
        chk("bp2_res", 32'({gt, eq, lt}), 32'(R_EQ));
        step();
        chk("bp2_idle", 32'(in_ready), 32'd1);

        // Reset in the middle of a scan discards the pair.
        a = 8'h00;
        b = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("mrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mrst_in_ready_during", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        chk("mrst_busy_after", 32'(busy), 32'd0);
        chk("mrst_res_after", 32'({gt, eq, lt}), 32'(R_NO));
        chk("mrst_valid_after", 32'(out_valid), 32'd0);
        #1;
        chk("mrst_in_ready_after", 32'(in_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("mrst_no_valid_%0d", c), 32'(out_valid), 32'd0);
        end

        // Streaming: back-to-back pairs with both handshakes held high.
        nres = 0;
        a = 8'h80;
        b = 8'h00;
        in_valid = 1'b1;
        step();
        a = 8'h44;
        b = 8'h44;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (out_valid) nres++;
            case (c)
                1: begin
                    chk("st_first_res", 32'({gt, eq, lt}), 32'(R_GT));
                    chk("st_first_res_s", 32'({gt_s, eq_s, lt_s}), 32'(R_LT));
                end
                2: begin
                    chk("st_gap_valid", 32'(out_valid), 32'd0);
                    chk("st_gap_in_ready", 32'(in_ready), 32'd1);
                end
                3: begin
                    chk("st_second_accept", 32'(busy), 32'd1);
                    in_valid = 1'b0;
                end
                4, 5, 6: chk($sformatf("st_early_valid_c%0d", c), 32'(out_valid), 32'd0);
                7: begin
                    chk("st_second_valid", 32'(out_valid), 32'd1);
                    chk("st_second_res", 32'({gt, eq, lt}), 32'(R_EQ));
                end
                default: chk("st_end_idle", 32'(in_ready), 32'd1);
            endcase
        end
        chk("st_result_count", 32'(nres), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
